rmw_tag_scheduler: RTL

Issue-side controller for the long-latency read-modify-write path. It accepts `issue_t` commands, allocates one of `N`=64 tags, emits tagged reads to memory, and absorbs out-of-order read responses. It applies `op`/`imm` and schedules write-backs. A same-`id` hazard scoreboard keeps at most one operation per `id` in flight, so no update to a given word is lost.

---
 rtl/rmw_tag_scheduler_pkg.sv | 53 +++++
 rtl/rmw_tag_scheduler_if.sv | 37 +++
 rtl/rmw_tag_scheduler_pri_enc.sv | 24 ++
 rtl/rmw_tag_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rmw_tag_scheduler_pkg.sv
// Shared types for the read-modify-write tag scheduler: command, context entry and tag widths.
// The op helper applies an immediate to returned read data, modulo 2^32.
package rmw_tag_scheduler_pkg;

    localparam int N      = 64;
    localparam int PTR_W  = $clog2(N);
    localparam int ID_W   = 16;
    localparam int WORD_W = 32;

    typedef logic [PTR_W-1:0]  tag_t;
    typedef logic [PTR_W:0]    cnt_t;
    typedef logic [ID_W-1:0]   id_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ADDI = 2'd1,
        OP_SUBI = 2'd2,
        OP_MOVI = 2'd3
    } op_t;

    typedef struct packed {
        id_t   id;
        word_t imm;
        op_t   op;
    } issue_t;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } ctx_state_t;

    typedef struct packed {
        ctx_state_t state;
        id_t        id;
        word_t      imm;
        op_t        op;
        word_t      result;
    } ctx_t;

    function automatic word_t apply_op(input op_t op, input word_t rd_dat, input word_t imm);
        word_t res;
        case (op)
            OP_ADDI: res = rd_dat + imm;
            OP_SUBI: res = rd_dat - imm;
            OP_MOVI: res = imm;
            default: res = rd_dat;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rmw_tag_scheduler_if.sv
// Bundle of issue, read, response and write-back signals around the tag scheduler.
// The slave modport is the scheduler's view; master is the environment driving it.
interface rmw_tag_scheduler_if;
    import rmw_tag_scheduler_pkg::*;

    logic   in_vld;
    issue_t in;
    logic   in_accept;

    logic   rd_vld;
    tag_t   rd_tag;
    id_t    rd_id;
    logic   rd_rdy;

    logic   rsp_vld;
    tag_t   rsp_tag;
    word_t  rsp_dat;

    logic   wr_vld;
    id_t    wr_id;
    word_t  wr_dat;
    logic   wr_rdy;

    cnt_t   inflight;
    logic   err;

    modport master (
        output in_vld, in, rd_rdy, rsp_vld, rsp_tag, rsp_dat, wr_rdy,
        input  in_accept, rd_vld, rd_tag, rd_id, wr_vld, wr_id, wr_dat, inflight, err
    );

    modport slave (
        input  in_vld, in, rd_rdy, rsp_vld, rsp_tag, rsp_dat, wr_rdy,
        output in_accept, rd_vld, rd_tag, rd_id, wr_vld, wr_id, wr_dat, inflight, err
    );

endinterface

// File: rtl/rmw_tag_scheduler_pri_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
// Used to pick the first FREE entry for allocation and the first DONE entry for write-back.
module rmw_pri_enc #(
    parameter int W     = 64,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/rmw_tag_scheduler.sv
// Issue-side controller for the long-latency RMW path: allocates tags, issues reads,
// absorbs out-of-order responses and drains write-backs, with one op in flight per id.
module rmw_tag_scheduler
    import rmw_tag_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    rmw_tag_scheduler_if.slave bus
);

    ctx_t         w_ctx [N];
    logic [N-1:0] w_free_vec;
    logic [N-1:0] w_done_vec;
    tag_t         w_free_idx;
    tag_t         w_done_idx;
    logic         w_free_any;
    logic         w_done_any;

    issue_t       w_cmd;
    logic         w_hazard;
    logic         w_full;
    logic         w_rd_slot_free;
    logic         w_accept;
    logic         w_alloc;
    logic         w_rsp_hit;
    logic         w_rsp_bad;
    logic         w_wr_fire;

    logic         r_rd_vld;
    tag_t         r_rd_tag;
    id_t          r_rd_id;
    cnt_t         r_inflight;
    logic         r_err;

    assign w_cmd = bus.in;

    // Status vectors and the same-id hazard are all taken from start-of-cycle state,
    // so an entry being freed this cycle still blocks its id and its tag.
    always_comb begin
        w_free_vec = '0;
        w_done_vec = '0;
        w_hazard   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_free_vec[i] = (w_ctx[i].state == FREE);
            w_done_vec[i] = (w_ctx[i].state == DONE);
            if ((w_ctx[i].state != FREE) && (w_ctx[i].id == w_cmd.id)) begin
                w_hazard = 1'b1;
            end
        end
    end

    rmw_pri_enc #(
        .W     (N),
        .IDX_W (PTR_W)
    ) u_free_pick (
        .i_vec (w_free_vec),
        .o_idx (w_free_idx),
        .o_any (w_free_any)
    );

    rmw_pri_enc #(
        .W     (N),
        .IDX_W (PTR_W)
    ) u_done_pick (
        .i_vec (w_done_vec),
        .o_idx (w_done_idx),
        .o_any (w_done_any)
    );

    assign w_full         = ~w_free_any;
    assign w_rd_slot_free = ~r_rd_vld | bus.rd_rdy;
    assign w_accept       = rst_n & bus.in_vld &
                            ((w_cmd.op == OP_NOP) | (~w_full & ~w_hazard & w_rd_slot_free));
    assign w_alloc        = w_accept & (w_cmd.op != OP_NOP);
    assign w_rsp_hit      = bus.rsp_vld & (w_ctx[bus.rsp_tag].state == PEND);
    assign w_rsp_bad      = bus.rsp_vld & ~w_rsp_hit;
    assign w_wr_fire      = w_done_any & bus.wr_rdy;

    // Alloc targets a FREE entry, a hit a PEND one, a write a DONE one: the three never collide.
    for (genvar g = 0; g < N; g++) begin : g_ctx
        ctx_t r_entry;
        logic w_alloc_here;
        logic w_rsp_here;
        logic w_free_here;

        assign w_alloc_here = w_alloc & (w_free_idx == tag_t'(g));
        assign w_rsp_here   = w_rsp_hit & (bus.rsp_tag == tag_t'(g));
        assign w_free_here  = w_wr_fire & (w_done_idx == tag_t'(g));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_entry.state <= FREE;
            end else if (w_alloc_here) begin
                r_entry.state  <= PEND;
                r_entry.id     <= w_cmd.id;
                r_entry.imm    <= w_cmd.imm;
                r_entry.op     <= w_cmd.op;
                r_entry.result <= '0;
            end else if (w_rsp_here) begin
                r_entry.state  <= DONE;
                r_entry.result <= apply_op(r_entry.op, bus.rsp_dat, r_entry.imm);
            end else if (w_free_here) begin
                r_entry.state <= FREE;
            end
        end

        assign w_ctx[g] = r_entry;
    end

    // Read request register is only reloaded when the slot is free, so rd_* stays stable under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_vld   <= 1'b0;
            r_rd_tag   <= '0;
            r_rd_id    <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_rd_vld <= 1'b1;
                r_rd_tag <= w_free_idx;
                r_rd_id  <= w_cmd.id;
            end else if (bus.rd_rdy) begin
                r_rd_vld <= 1'b0;
            end

            if (w_alloc && !w_wr_fire) begin
                r_inflight <= r_inflight + cnt_t'(1);
            end else if (!w_alloc && w_wr_fire) begin
                r_inflight <= r_inflight - cnt_t'(1);
            end

            if (w_rsp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_accept = w_accept;
    assign bus.rd_vld    = r_rd_vld;
    assign bus.rd_tag    = r_rd_tag;
    assign bus.rd_id     = r_rd_id;
    assign bus.wr_vld    = w_done_any;
    assign bus.wr_id     = w_ctx[w_done_idx].id;
    assign bus.wr_dat    = w_ctx[w_done_idx].result;
    assign bus.inflight  = r_inflight;
    assign bus.err       = r_err;

endmodule
